std_mem_d1_copy_engine: RTL and testbench



---
 rtl/std_mem_d1_copy_engine.sv | 86 ++++++++
 tb/tb_std_mem_d1_copy_engine.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/std_mem_d1_copy_engine.sv
// Copies SIZE words from a combinational-read source memory into a
// registered-write destination memory, one write per destination done.
module std_mem_d1_copy_engine #(
  parameter int WIDTH    = 32,
  parameter int SIZE     = 16,
  parameter int IDX_SIZE = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                go,
  input  logic [WIDTH-1:0]    src_read_data,
  input  logic                dst_done,
  output logic [IDX_SIZE-1:0] src_addr0,
  output logic [IDX_SIZE-1:0] dst_addr0,
  output logic [WIDTH-1:0]    dst_write_data,
  output logic                dst_write_en,
  output logic                done,
  output logic [1:0]          state_dbg
);

  // Handshakes: go is a level held by the parent until it sees the one-cycle
  // done pulse, and go is only sampled in IDLE. Each dst_write_en pulse lasts
  // one cycle. The next write waits until dst_done is seen in WAIT, so a
  // dst_done that arrives in any other state has no effect.
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [IDX_SIZE-1:0] LAST_IDX = IDX_SIZE'(SIZE - 1);

  logic [1:0]          state;
  logic [1:0]          state_next;
  logic [IDX_SIZE-1:0] idx;
  logic [IDX_SIZE-1:0] idx_next;

  always_comb begin
    state_next = state;
    idx_next   = idx;
    case (state)
      IDLE: begin
        idx_next = '0;
        if (go) state_next = WRITE;
      end
      WRITE: state_next = WAIT;
      WAIT: begin
        if (dst_done) begin
          if (idx == LAST_IDX) begin
            // idx is cleared on entry so DONE already shows address 0
            idx_next   = '0;
            state_next = DONE;
          end else begin
            idx_next   = idx + 1'b1;
            state_next = WRITE;
          end
        end
      end
      DONE: begin
        idx_next   = '0;
        state_next = IDLE;
      end
      default: begin
        idx_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  assign src_addr0      = idx;
  assign dst_addr0      = idx;
  assign dst_write_en   = (state == WRITE);
  assign dst_write_data = (state == WRITE) ? src_read_data : '0;
  assign done           = (state == DONE);
  assign state_dbg      = state;

endmodule

// File: tb/tb_std_mem_d1_copy_engine.sv
// Bench for std_mem_d1_copy_engine: three instances (SIZE 4, 8, 1) with
// memory models; writes and done pulses are checked against a scoreboard.
module tb_std_mem_d1_copy_engine;

  localparam int W  = 32;
  localparam int IW = 4;
  localparam int N  = 3;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd2;

  function automatic int size_of(input int i);
    case (i)
      0:       return 4;
      1:       return 8;
      default: return 1;
    endcase
  endfunction

  logic          clk;
  logic          reset;
  logic          go             [N];
  logic [W-1:0]  src_read_data  [N];
  logic          dst_done       [N];
  logic [IW-1:0] src_addr0      [N];
  logic [IW-1:0] dst_addr0      [N];
  logic [W-1:0]  dst_write_data [N];
  logic          dst_write_en   [N];
  logic          done           [N];
  logic [1:0]    state_dbg      [N];

  logic [W-1:0]  src_mem     [N][16];
  logic [W-1:0]  dst_mem     [N][16];
  logic          pend        [N];
  logic [3:0]    dly         [N];
  int            stall_word  [N];
  logic [3:0]    stall_extra [N];
  logic          force_done  [N];
  logic          clr_dst;

  logic [51:0]   exp_q[$];
  logic [15:0]   done_q[$];
  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  int            sel = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    std_mem_d1_copy_engine #(
      .WIDTH(W), .SIZE(size_of(g)), .IDX_SIZE(IW)
    ) u_dut (
      .clk            (clk),
      .reset          (reset),
      .go             (go[g]),
      .src_read_data  (src_read_data[g]),
      .dst_done       (dst_done[g]),
      .src_addr0      (src_addr0[g]),
      .dst_addr0      (dst_addr0[g]),
      .dst_write_data (dst_write_data[g]),
      .dst_write_en   (dst_write_en[g]),
      .done           (done[g]),
      .state_dbg      (state_dbg[g])
    );
    assign src_read_data[g] = src_mem[g][src_addr0[g]];
    assign dst_done[g]      = (pend[g] && dly[g] == 4'd0) || force_done[g];
  end

  // Destination memory: done one cycle after write_en, plus an optional
  // extra delay on one chosen word.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (dst_write_en[i]) begin
        dst_mem[i][dst_addr0[i]] <= dst_write_data[i];
        pend[i] <= 1'b1;
        dly[i]  <= (int'(dst_addr0[i]) == stall_word[i]) ? stall_extra[i] : 4'd0;
      end else if (pend[i]) begin
        if (dly[i] == 4'd0) pend[i] <= 1'b0;
        else dly[i] <= dly[i] - 4'd1;
      end
      if (reset) pend[i] <= 1'b0;
      if (clr_dst)
        for (int k = 0; k < 16; k++) dst_mem[i][k] <= 32'hDEAD_0000 | W'(k);
    end
  end

  // Advance one cycle and pop/compare any write or done the DUTs produce.
  task automatic step_cycle();
    logic [51:0] e;
    logic [15:0] dc;
    @(negedge clk);
    cyc = cyc + 1;
    for (int i = 0; i < N; i++) begin
      if (dst_write_en[i]) begin
        total = total + 1;
        if (i != sel || exp_q.size() == 0) begin
          bad = bad + 1;
          $display("FAIL unexpected_write inst=%0d cyc=%0d addr=%0d got_data=%h required=no_write",
                   i, cyc, dst_addr0[i], dst_write_data[i]);
        end else begin
          e = exp_q.pop_front();
          if ({cyc[15:0], dst_addr0[i], dst_write_data[i]} !== e) begin
            bad = bad + 1;
            $display("FAIL write inst=%0d got cyc=%0d addr=%0d data=%h required cyc=%0d addr=%0d data=%h",
                     i, cyc, dst_addr0[i], dst_write_data[i], e[51:36], e[35:32], e[31:0]);
          end
        end
      end
      if (done[i]) begin
        total = total + 1;
        if (i != sel || done_q.size() == 0) begin
          bad = bad + 1;
          $display("FAIL unexpected_done inst=%0d cyc=%0d required=no_done", i, cyc);
        end else begin
          dc = done_q.pop_front();
          if (cyc[15:0] !== dc) begin
            bad = bad + 1;
            $display("FAIL done_cycle inst=%0d got=%0d required=%0d", i, cyc, dc);
          end
        end
      end
    end
  endtask

  task automatic push_copy(input int inst, input int t0, input int n, input int stall_k,
                           input int extra, input bit with_done);
    int c;
    logic [IW-1:0] a;
    for (int k = 0; k < n; k++) begin
      c = t0 + 1 + 2 * k + ((k > stall_k) ? extra : 0);
      a = k[IW-1:0];
      exp_q.push_back({c[15:0], a, src_mem[inst][k]});
    end
    if (with_done) begin
      c = t0 + 1 + 2 * n + ((stall_k < n) ? extra : 0);
      done_q.push_back(c[15:0]);
    end
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    do begin
      step_cycle();
      n = n + 1;
    end while (!done[sel] && n < limit);
    if (!done[sel]) begin
      total = total + 1;
      bad = bad + 1;
      $display("FAIL done_timeout inst=%0d got=no_done required=done_within_%0d", sel, limit);
    end
  endtask

  task automatic clear_dst();
    clr_dst = 1'b1;
    step_cycle();
    clr_dst = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step_cycle();
    step_cycle();
    for (int i = 0; i < N; i++) begin
      total = total + 1;
      if ({src_addr0[i], dst_addr0[i], dst_write_data[i], dst_write_en[i], done[i], state_dbg[i]} !== '0) begin
        bad = bad + 1;
        $display("FAIL reset_outputs inst=%0d got addr=%0d/%0d data=%h we=%b done=%b state=%0d required all_zero",
                 i, src_addr0[i], dst_addr0[i], dst_write_data[i], dst_write_en[i], done[i], state_dbg[i]);
      end
    end
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step_cycle();
      for (int i = 0; i < N; i++) begin
        total = total + 1;
        if (state_dbg[i] !== S_IDLE || dst_write_en[i] !== 1'b0) begin
          bad = bad + 1;
          $display("FAIL idle_hold inst=%0d got state=%0d we=%b required state=0 we=0",
                   i, state_dbg[i], dst_write_en[i]);
        end
      end
    end
  endtask

  task automatic test_basic_copy();
    int t0;
    sel = 0;
    for (int k = 0; k < 4; k++) src_mem[0][k] = W'(32'h11 * (k + 1));
    clear_dst();
    go[0] = 1'b1;
    t0 = cyc;
    push_copy(0, t0, 4, 99, 0, 1'b1);
    wait_done(40);
    go[0] = 1'b0;
    step_cycle();
    step_cycle();
    total = total + 1;
    if (exp_q.size() != 0 || done_q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL basic_drain got pending=%0d/%0d required 0/0", exp_q.size(), done_q.size());
    end
    for (int k = 0; k < 4; k++) begin
      total = total + 1;
      if (dst_mem[0][k] !== W'(32'h11 * (k + 1))) begin
        bad = bad + 1;
        $display("FAIL basic_contents addr=%0d got=%h required=%h", k, dst_mem[0][k], 32'h11 * (k + 1));
      end
    end
  endtask

  task automatic test_stalled_done();
    int t0;
    sel = 0;
    for (int k = 0; k < 4; k++) src_mem[0][k] = $urandom;
    stall_word[0]  = 2;
    stall_extra[0] = 4'd3;
    go[0] = 1'b1;
    t0 = cyc;
    push_copy(0, t0, 4, 2, 3, 1'b1);
    while (cyc < t0 + 7) step_cycle();
    total = total + 1;
    if (state_dbg[0] !== S_WAIT || dst_addr0[0] !== 4'd2 || dst_write_en[0] !== 1'b0) begin
      bad = bad + 1;
      $display("FAIL stall_hold got state=%0d addr=%0d we=%b required state=2 addr=2 we=0",
               state_dbg[0], dst_addr0[0], dst_write_en[0]);
    end
    wait_done(40);
    go[0] = 1'b0;
    step_cycle();
    stall_word[0] = 99;
    total = total + 1;
    if (exp_q.size() != 0 || done_q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL stall_drain got pending=%0d/%0d required 0/0", exp_q.size(), done_q.size());
    end
  endtask

  task automatic test_reset_mid_copy();
    int t0;
    sel = 1;
    for (int k = 0; k < 8; k++) src_mem[1][k] = $urandom;
    clear_dst();
    go[1] = 1'b1;
    t0 = cyc;
    push_copy(1, t0, 4, 99, 0, 1'b0);
    while (cyc < t0 + 8) step_cycle();
    total = total + 1;
    if (state_dbg[1] !== S_WAIT || dst_addr0[1] !== 4'd3) begin
      bad = bad + 1;
      $display("FAIL mid_pre_reset got state=%0d addr=%0d required state=2 addr=3", state_dbg[1], dst_addr0[1]);
    end
    go[1] = 1'b0;
    reset = 1'b1;
    step_cycle();
    total = total + 1;
    if ({src_addr0[1], dst_addr0[1], dst_write_data[1], dst_write_en[1], done[1], state_dbg[1]} !== '0) begin
      bad = bad + 1;
      $display("FAIL mid_reset_outputs got addr=%0d data=%h we=%b done=%b state=%0d required all_zero",
               dst_addr0[1], dst_write_data[1], dst_write_en[1], done[1], state_dbg[1]);
    end
    reset = 1'b0;
    repeat (6) step_cycle();
    total = total + 1;
    if (exp_q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL mid_partial_writes got pending=%0d required 0", exp_q.size());
    end
    for (int k = 0; k < 8; k++) begin
      total = total + 1;
      if (dst_mem[1][k] !== ((k < 4) ? src_mem[1][k] : (32'hDEAD_0000 | W'(k)))) begin
        bad = bad + 1;
        $display("FAIL mid_contents addr=%0d got=%h", k, dst_mem[1][k]);
      end
    end
    go[1] = 1'b1;
    t0 = cyc;
    push_copy(1, t0, 8, 99, 0, 1'b1);
    wait_done(60);
    go[1] = 1'b0;
    step_cycle();
    total = total + 1;
    if (exp_q.size() != 0 || done_q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL restart_drain got pending=%0d/%0d required 0/0", exp_q.size(), done_q.size());
    end
    for (int k = 0; k < 8; k++) begin
      total = total + 1;
      if (dst_mem[1][k] !== src_mem[1][k]) begin
        bad = bad + 1;
        $display("FAIL restart_contents addr=%0d got=%h required=%h", k, dst_mem[1][k], src_mem[1][k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    sel = 2;
    src_mem[2][0] = $urandom;
    clear_dst();
    go[2] = 1'b1;
    t0 = cyc;
    push_copy(2, t0, 1, 99, 0, 1'b1);
    push_copy(2, t0 + 4, 1, 99, 0, 1'b1);
    wait_done(20);
    wait_done(20);
    go[2] = 1'b0;
    repeat (4) step_cycle();
    total = total + 1;
    if (exp_q.size() != 0 || done_q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL b2b_drain got pending=%0d/%0d required 0/0", exp_q.size(), done_q.size());
    end
    total = total + 1;
    if (dst_mem[2][0] !== src_mem[2][0]) begin
      bad = bad + 1;
      $display("FAIL b2b_contents got=%h required=%h", dst_mem[2][0], src_mem[2][0]);
    end
  endtask

  task automatic test_spurious_done();
    int t0;
    sel = 0;
    for (int k = 0; k < 4; k++) src_mem[0][k] = $urandom_range(1, 1000);
    force_done[0] = 1'b1;
    repeat (3) step_cycle();
    force_done[0] = 1'b0;
    total = total + 1;
    if (state_dbg[0] !== S_IDLE || dst_write_en[0] !== 1'b0) begin
      bad = bad + 1;
      $display("FAIL spurious_idle got state=%0d we=%b required state=0 we=0", state_dbg[0], dst_write_en[0]);
    end
    go[0] = 1'b1;
    t0 = cyc;
    push_copy(0, t0, 4, 99, 0, 1'b1);
    step_cycle();
    force_done[0] = 1'b1;
    step_cycle();
    force_done[0] = 1'b0;
    step_cycle();
    force_done[0] = 1'b1;
    step_cycle();
    force_done[0] = 1'b0;
    wait_done(40);
    go[0] = 1'b0;
    step_cycle();
    total = total + 1;
    if (exp_q.size() != 0 || done_q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL spurious_drain got pending=%0d/%0d required 0/0", exp_q.size(), done_q.size());
    end
  endtask

  initial begin
    reset   = 1'b1;
    clr_dst = 1'b0;
    for (int i = 0; i < N; i++) begin
      go[i]          = 1'b0;
      force_done[i]  = 1'b0;
      stall_word[i]  = 99;
      stall_extra[i] = 4'd0;
      for (int k = 0; k < 16; k++) src_mem[i][k] = '0;
    end
    test_reset();
    test_basic_copy();
    test_stalled_done();
    test_reset_mid_copy();
    test_back_to_back();
    test_spurious_done();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=no_finish required=finish_before_200000");
    $fatal(1, "watchdog");
  end

endmodule
